// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state and digit-select encodings for the stopwatch controller
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_ADJ   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEC0 = 2'b00,
      SEL_SEC1 = 2'b01,
      SEL_MIN0 = 2'b10,
      SEL_MIN1 = 2'b11
   } sel_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability-counter debouncer and press pulse
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk_c,
   input  logic reset_c,
   input  logic raw,
   output logic pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q;
   logic          pulse_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_c) begin
      if (reset_c) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         pulse_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES)) begin
            // accept the new level; only a rising acceptance is reported
            level_q <= sync2_q;
            pulse_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - IDLE/RUN/PAUSE/ADJUST sequencer with 1 Hz and adjust-step strobes
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIV_1HZ   = 100_000_000,
   parameter int DIV_ADJ   = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk_c,
   input  logic       reset_c,
   input  logic       btn_pause_raw,
   input  logic       btn_clr_raw,
   input  logic       sw_adj,
   input  logic [1:0] sw_sel,
   output logic       cnt_en,
   output logic       adj_en,
   output logic [1:0] adj_sel,
   output logic       clr,
   output logic       blink_on,
   output logic [1:0] state
);

   localparam int PW1 = $clog2(DIV_1HZ);
   localparam int PWA = $clog2(DIV_ADJ);

   logic           pause_pulse, clr_pulse;
   logic           adj_s1_q, adj_s2_q;
   logic [1:0]     sel_s1_q, sel_s2_q;
   state_e         state_q, state_d;
   logic [PW1-1:0] pre1_q, pre1_d;
   logic [PWA-1:0] prea_q, prea_d;
   logic           cnt_en_q, cnt_en_d;
   logic           adj_en_q, adj_en_d;
   logic           clr_q, clr_d;
   logic           blink_q, blink_d;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
      .clk_c   (clk_c),
      .reset_c (reset_c),
      .raw     (btn_pause_raw),
      .pulse   (pause_pulse)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk_c   (clk_c),
      .reset_c (reset_c),
      .raw     (btn_clr_raw),
      .pulse   (clr_pulse)
   );

   always_comb begin
      state_d  = state_q;
      clr_d    = 1'b0;
      pre1_d   = pre1_q;
      cnt_en_d = 1'b0;
      prea_d   = prea_q;
      adj_en_d = 1'b0;
      blink_d  = 1'b1;

      if (clr_pulse) begin
         state_d = ST_IDLE;
         clr_d   = 1'b1;
      end else if (adj_s2_q && state_q != ST_ADJ) begin
         state_d = ST_ADJ;
      end else if (!adj_s2_q && state_q == ST_ADJ) begin
         state_d = ST_PAUSE;
      end else if (pause_pulse) begin
         case (state_q)
            ST_IDLE, ST_PAUSE: state_d = ST_RUN;
            ST_RUN:            state_d = ST_PAUSE;
            default:           state_d = state_q;
         endcase
      end

      // strobes are qualified by the next state so a leaving edge never fires one
      if (state_d == ST_RUN) begin
         if (state_q != ST_RUN) begin
            pre1_d = '0;
         end else if (pre1_q == PW1'(DIV_1HZ - 1)) begin
            pre1_d   = '0;
            cnt_en_d = 1'b1;
         end else begin
            pre1_d = pre1_q + PW1'(1);
         end
      end

      if (state_d == ST_ADJ) begin
         if (state_q != ST_ADJ) begin
            prea_d = '0;
         end else if (prea_q == PWA'(DIV_ADJ - 1)) begin
            prea_d   = '0;
            adj_en_d = 1'b1;
            blink_d  = ~blink_q;
         end else begin
            prea_d  = prea_q + PWA'(1);
            blink_d = blink_q;
         end
      end
   end

   always_ff @(posedge clk_c) begin
      if (reset_c) begin
         adj_s1_q <= 1'b0;
         adj_s2_q <= 1'b0;
         sel_s1_q <= 2'b00;
         sel_s2_q <= 2'b00;
         state_q  <= ST_IDLE;
         pre1_q   <= '0;
         prea_q   <= '0;
         cnt_en_q <= 1'b0;
         adj_en_q <= 1'b0;
         clr_q    <= 1'b0;
         blink_q  <= 1'b1;
      end else begin
         adj_s1_q <= sw_adj;
         adj_s2_q <= adj_s1_q;
         sel_s1_q <= sw_sel;
         sel_s2_q <= sel_s1_q;
         state_q  <= state_d;
         pre1_q   <= pre1_d;
         prea_q   <= prea_d;
         cnt_en_q <= cnt_en_d;
         adj_en_q <= adj_en_d;
         clr_q    <= clr_d;
         blink_q  <= blink_d;
      end
   end

   assign cnt_en   = cnt_en_q;
   assign adj_en   = adj_en_q;
   assign adj_sel  = sel_s2_q;
   assign clr      = clr_q;
   assign blink_on = blink_q;
   assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench: per-cycle reference model vs stopwatch_ctrl
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int DIV_1HZ = 10;
   localparam int DIV_ADJ = 5;
   localparam int DB      = 4;

   logic       clk_c = 1'b0;
   logic       reset_c = 1'b1;
   logic       btn_pause_raw = 1'b0;
   logic       btn_clr_raw = 1'b0;
   logic       sw_adj = 1'b0;
   logic [1:0] sw_sel = 2'b00;
   logic       cnt_en, adj_en, clr, blink_on;
   logic [1:0] adj_sel, state;

   stopwatch_ctrl #(.DIV_1HZ(DIV_1HZ), .DIV_ADJ(DIV_ADJ), .DB_CYCLES(DB)) dut (
      .clk_c         (clk_c),
      .reset_c       (reset_c),
      .btn_pause_raw (btn_pause_raw),
      .btn_clr_raw   (btn_clr_raw),
      .sw_adj        (sw_adj),
      .sw_sel        (sw_sel),
      .cnt_en        (cnt_en),
      .adj_en        (adj_en),
      .adj_sel       (adj_sel),
      .clr           (clr),
      .blink_on      (blink_on),
      .state         (state)
   );

   always #5 clk_c = ~clk_c;

   typedef struct packed {
      logic [1:0] st;
      logic       cnt;
      logic       adj;
      logic       clr;
      logic       blink;
      logic [1:0] sel;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   seen_cnt = 0, seen_adj = 0, seen_clr = 0;
   int   exp_cnt = 0, exp_adj = 0, exp_clr = 0;

   // reference model: input histories plus time-in-state counters
   state_e     m_st = ST_IDLE;
   int         t_run = 0, t_adj = 0;
   bit         m_pp = 0, m_cp = 0, m_pacc = 0, m_cacc = 0;
   bit         ph[$], ch[$], ah[$];
   logic [1:0] sh[$];

   function automatic void model_reset();
      ph.delete(); ch.delete(); ah.delete(); sh.delete();
      for (int i = 0; i < DB + 3; i++) begin
         ph.push_back(1'b0); ch.push_back(1'b0);
         ah.push_back(1'b0); sh.push_back(2'b00);
      end
   endfunction

   // a level is accepted once DB+1 consecutive synchronised samples disagree with it
   function automatic bit window_flip(input bit h[$], input bit acc);
      int sz = h.size();
      for (int i = sz - 3 - DB; i <= sz - 3; i++)
         if (h[i] == acc) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk_c) begin : model
      exp_t   e;
      state_e nst;
      bit     adj_s;
      e = '0;
      if (reset_c) begin
         model_reset();
         m_st = ST_IDLE; t_run = 0; t_adj = 0;
         m_pp = 0; m_cp = 0; m_pacc = 0; m_cacc = 0;
         e.blink = 1'b1;
      end else begin
         ph.push_back(btn_pause_raw); ch.push_back(btn_clr_raw);
         ah.push_back(sw_adj);        sh.push_back(sw_sel);
         while (ph.size() > DB + 8) begin
            void'(ph.pop_front()); void'(ch.pop_front());
            void'(ah.pop_front()); void'(sh.pop_front());
         end
         adj_s = ah[ah.size() - 3];
         nst = m_st;
         if (m_cp) begin
            nst = ST_IDLE;
            e.clr = 1'b1;
         end else if (adj_s && m_st != ST_ADJ) nst = ST_ADJ;
         else if (!adj_s && m_st == ST_ADJ)  nst = ST_PAUSE;
         else if (m_pp) begin
            if (m_st == ST_RUN)      nst = ST_PAUSE;
            else if (m_st != ST_ADJ) nst = ST_RUN;
         end
         if (nst == ST_RUN) begin
            if (m_st == ST_RUN) begin
               t_run++;
               e.cnt = (t_run % DIV_1HZ == 0);
            end else t_run = 0;
         end
         e.blink = 1'b1;
         if (nst == ST_ADJ) begin
            if (m_st == ST_ADJ) begin
               t_adj++;
               e.adj   = (t_adj % DIV_ADJ == 0);
               e.blink = ((t_adj / DIV_ADJ) % 2 == 0);
            end else t_adj = 0;
         end
         e.st = nst;
         e.sel = sh[sh.size() - 2];
         m_st = nst;
         m_pp = 0;
         if (window_flip(ph, m_pacc)) begin m_pacc = !m_pacc; m_pp = m_pacc; end
         m_cp = 0;
         if (window_flip(ch, m_cacc)) begin m_cacc = !m_cacc; m_cp = m_cacc; end
      end
      sb_q.push_back(e);
   end

   always @(negedge clk_c) begin : monitor
      exp_t e, g;
      g.st = state; g.cnt = cnt_en; g.adj = adj_en; g.clr = clr;
      g.blink = blink_on; g.sel = adj_sel;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty t=%0t got outputs with no expectation", $time);
      end else begin
         e = sb_q.pop_front();
         exp_cnt += int'(e.cnt); exp_adj += int'(e.adj); exp_clr += int'(e.clr);
         if (g !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got st=%0d cnt=%0b adj=%0b clr=%0b blink=%0b sel=%0d expected st=%0d cnt=%0b adj=%0b clr=%0b blink=%0b sel=%0d",
                     $time, g.st, g.cnt, g.adj, g.clr, g.blink, g.sel,
                     e.st, e.cnt, e.adj, e.clr, e.blink, e.sel);
         end
      end
      seen_cnt += int'(cnt_en === 1'b1); seen_adj += int'(adj_en === 1'b1);
      seen_clr += int'(clr === 1'b1);
      checks++;
      if (int'(cnt_en === 1'b1) + int'(adj_en === 1'b1) + int'(clr === 1'b1) > 1) begin
         errors++;
         $display("FAIL strobe_exclusive t=%0t got cnt=%0b adj=%0b clr=%0b expected at most one high",
                  $time, cnt_en, adj_en, clr);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_c);
   endtask

   task automatic press_pause(input int hold);
      @(negedge clk_c) btn_pause_raw = 1'b1;
      cyc(hold);
      btn_pause_raw = 1'b0;
   endtask

   task automatic press_clr(input int hold);
      @(negedge clk_c) btn_clr_raw = 1'b1;
      cyc(hold);
      btn_clr_raw = 1'b0;
   endtask

   task automatic wait_model(input state_e st, input int budget, input string what);
      int n = 0;
      while (m_st != st && n < budget) begin
         @(negedge clk_c);
         n++;
      end
      checks++;
      if (m_st != st) begin
         errors++;
         $display("FAIL wait_%s got state=%0d expected %0d within %0d cycles", what, m_st, st, budget);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout got no finish expected finish before limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int act, n;
      model_reset();
      cyc(3);
      reset_c = 1'b0;
      cyc(100);

      press_pause(DB + 2 + $urandom_range(0, 4));
      wait_model(ST_RUN, 20, "run1");
      cyc(35 + $urandom_range(0, 9));

      for (int i = 0; i < 3; i++) begin
         press_pause(3);
         cyc(3);
      end
      cyc(10);
      press_pause(DB + 3);
      wait_model(ST_PAUSE, 20, "pause1");
      cyc(25);

      press_pause(DB + 4);
      wait_model(ST_RUN, 20, "run2");
      cyc($urandom_range(3, 12));
      sw_adj = 1'b1;
      sw_sel = SEL_MIN0;
      wait_model(ST_ADJ, 10, "adj1");
      cyc(18);
      press_pause(DB + 3);
      cyc(15);
      sw_adj = 1'b0;
      wait_model(ST_PAUSE, 10, "adj_exit");
      cyc(15);

      press_pause(DB + 2);
      wait_model(ST_RUN, 20, "run3");
      cyc(13);
      press_clr(DB + 3);
      wait_model(ST_IDLE, 20, "clr_run");
      cyc(10);
      sw_adj = 1'b1;
      wait_model(ST_ADJ, 10, "adj2");
      cyc(12);
      press_clr(DB + 2);
      cyc(20);
      sw_adj = 1'b0;
      cyc(10);

      press_pause(DB + 2);
      wait_model(ST_RUN, 20, "run4");
      n = 0;
      while (!(m_st == ST_RUN && t_run % DIV_1HZ == DIV_1HZ - 1 && t_run > DIV_1HZ) && n < 60) begin
         @(negedge clk_c);
         n++;
      end
      reset_c = 1'b1;
      cyc(2);
      reset_c = 1'b0;
      cyc(5);
      press_pause(DB + 2);
      wait_model(ST_RUN, 20, "run5");
      cyc(25);

      for (int seg = 0; seg < 150; seg++) begin
         act = $urandom_range(0, 19);
         if (act < 7)       press_pause($urandom_range(1, 9));
         else if (act < 9)  press_clr($urandom_range(1, 9));
         else if (act < 11) begin @(negedge clk_c); sw_adj = ~sw_adj; end
         else if (act < 13) begin @(negedge clk_c); sw_sel = 2'($urandom_range(0, 3)); end
         else if (act == 13) begin
            @(negedge clk_c) reset_c = 1'b1;
            cyc($urandom_range(1, 3));
            reset_c = 1'b0;
         end
         cyc($urandom_range(0, 25));
      end
      sw_adj = 1'b0;
      cyc(20);

      checks++;
      if (seen_cnt != exp_cnt || seen_adj != exp_adj || seen_clr != exp_clr) begin
         errors++;
         $display("FAIL strobe_totals got cnt=%0d adj=%0d clr=%0d expected cnt=%0d adj=%0d clr=%0d",
                  seen_cnt, seen_adj, seen_clr, exp_cnt, exp_adj, exp_clr);
      end
      checks++;
      if (seen_cnt == 0 || seen_adj == 0 || seen_clr == 0) begin
         errors++;
         $display("FAIL strobe_activity got cnt=%0d adj=%0d clr=%0d expected all nonzero",
                  seen_cnt, seen_adj, seen_clr);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode and timing controller that sequences the mm:ss stopwatch digit counter. It debounces the raw pause and clear buttons and runs the IDLE/RUN/PAUSE/ADJUST state machine. It generates the 1 Hz count-enable and 2 Hz adjust-step strobes, plus the digit-select and blink signals. It sits between the board buttons and switches and the digit counter and display; the counter only ever sees clean single-cycle enables.

Parameters:
DIV_1HZ, 100_000_000, clk_c cycles per count strobe (must be >= 2).
DIV_ADJ, 50_000_000, clk_c cycles per adjust-step/blink strobe (must be >= 2).
DB_CYCLES, 1_000_000, cycles a synchronised button level must be stable before it is accepted (must be >= 1).

Ports:
clk_c  in  1  system clock; the only clock.
reset_c  in  1  synchronous, active-high reset.
btn_pause_raw  in  1  raw pause/run button, asynchronous, bouncy.
btn_clr_raw  in  1  raw clear button, asynchronous, bouncy.
sw_adj  in  1  adjust-mode switch, static level.
sw_sel  in  2  digit select: 00 sec ones, 01 sec tens, 10 min ones, 11 min tens.
cnt_en  out  1  one-cycle strobe: advance the stopwatch by 1 s.
adj_en  out  1  one-cycle strobe: increment the selected digit.
adj_sel  out  2  registered copy of sw_sel.
clr  out  1  one-cycle strobe: clear all digits to 00:00.
blink_on  out  1  display enable for the selected digit.
state  out  2  current FSM state (package encoding).

Behaviour:
- Reset (reset_c=1 at an edge) sets: state=IDLE, cnt_en=0, adj_en=0, clr=0, adj_sel=00, blink_on=1. All prescalers, debouncer counters and synchroniser flops go to 0.
- Each button passes through a 2-FF synchroniser and then a debouncer.
  - The stability counter increments while the synced level differs from the accepted level, and clears when they are equal.
  - At count DB_CYCLES the accepted level takes the synced value.
  - A registered one-cycle pulse fires on each accepted 0->1 transition, and never on release.
  - Latency: a raw press stable from before edge k produces a pulse high for the cycle after edge k+DB_CYCLES+2.
  - A bounce shorter than DB_CYCLES produces no pulse.
- sw_adj and sw_sel are 2-FF synchronised. adj_sel is the synced sw_sel.
- FSM transitions are evaluated each edge, highest priority first:
  1. reset_c.
  2. clr_pulse: any state -> IDLE; clr=1 for one cycle.
  3. adj_s=1 and state!=ADJUST -> ADJUST.
  4. adj_s=0 and state==ADJUST -> PAUSE.
  5. pause_pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. Ignored in ADJUST.
- A pause_pulse coinciding with a higher-priority event is dropped, not queued.
- 1 Hz prescaler (width $clog2(DIV_1HZ)):
  - Counts 0..DIV_1HZ-1 only in RUN.
  - Held in other states and cleared to 0 on every entry into RUN.
  - cnt_en=1 in the cycle after the prescaler wraps, so the first cnt_en comes exactly DIV_1HZ cycles after the RUN state is first visible.
  - Resuming from PAUSE restarts the full second; no partial-second carry.
- ADJ prescaler:
  - Counts 0..DIV_ADJ-1 only in ADJUST and is cleared on entry.
  - adj_en=1 one cycle on each wrap. blink_on toggles on the same wrap.
  - blink_on is forced to 1 outside ADJUST and set to 1 on entry.
- adj_en and cnt_en are never high in the same cycle, and never high together with clr.
- Leaving ADJUST cancels any in-progress prescale, so no late adj_en is issued.

Decomposition:
- stopwatch_pkg holds:
  - state encoding ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10, ST_ADJ=2'b11;
  - select encoding SEL_SEC0=00, SEL_SEC1=01, SEL_MIN0=10, SEL_MIN1=11.
- Sub-module btn_debounce (parameter DB_CYCLES; ports clk_c, reset_c, raw, pulse) is instantiated twice and contains the synchroniser, stability counter and edge pulse.

Test Plan:
All scenarios use DIV_1HZ=10, DIV_ADJ=5, DB_CYCLES=4.
1. Reset held 3 cycles, then released, no input -> state=00, all strobes 0, blink_on=1 for 100 cycles.
2. Clean btn_pause_raw press at edge k -> pulse after edge k+6. state=RUN from the following cycle. cnt_en is high every 10th cycle, first one 10 cycles after RUN is visible.
3. btn_pause_raw with 3-cycle high glitches spaced 3 cycles low -> no pulse, state unchanged. A second clean press in RUN -> PAUSE, and cnt_en stays 0.
4. In RUN, set sw_adj=1, sw_sel=10 -> ADJUST after sync. adj_sel=10, adj_en every 5 cycles, blink_on toggling every 5 cycles, cnt_en=0. A pause press is ignored. Drop sw_adj -> PAUSE with blink_on=1 and no further adj_en.
5. Clear press in RUN and in ADJUST (sw_adj still 1) -> clr is a single-cycle pulse and state=IDLE. On the next edge adj_s=1 forces ADJUST, proving the priority order.
6. reset_c asserted mid-RUN, one cycle before a prescaler wrap -> no cnt_en issued, state=IDLE. After release the next RUN entry gives its first cnt_en 10 cycles later.
